// File: rtl/ustawienie_pola.sv
// Bit-field set/clear/toggle/popcount unit: walks a field of i_arg_A one bit per clock
// under a start/busy/done handshake, flagging illegal index/length with o_error.
module ustawienie_pola #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_mode,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  input  logic [BITS-1:0] i_arg_C,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_busy,
  output logic            o_done
);
  localparam int IDXW = $clog2(BITS) + 1;
  localparam logic [BITS:0] LIM = (BITS+1)'(BITS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [1:0]        mode;
  logic [BITS-1:0]   work;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   cnt;
  logic [IDXW-1:0]   ones;

  logic [BITS-1:0]   bit_mask;
  logic              cur_bit;
  logic [BITS-1:0]   work_nx;
  logic [IDXW-1:0]   ones_nx;

  logic              b_neg, c_neg;
  logic [BITS:0]     b_ext, c_ext, sum;
  logic              arg_err;

  always_comb begin
    bit_mask = {{(BITS-1){1'b0}}, 1'b1} << idx;
    cur_bit  = |(work & bit_mask);
    work_nx  = work;
    case (mode)
      2'b00:   work_nx = work | bit_mask;
      2'b01:   work_nx = work & ~bit_mask;
      2'b10:   work_nx = work ^ bit_mask;
      default: work_nx = work;
    endcase
    ones_nx = ones + {{(IDXW-1){1'b0}}, cur_bit};
  end

  // Sum is only meaningful once both operands are known non-negative; BITS+1 bits avoid wrap.
  always_comb begin
    b_neg   = i_arg_B[BITS-1];
    c_neg   = i_arg_C[BITS-1];
    b_ext   = {1'b0, i_arg_B};
    c_ext   = {1'b0, i_arg_C};
    sum     = b_ext + c_ext;
    arg_err = b_neg || c_neg || (i_arg_C == '0) || (b_ext >= LIM) ||
              (!b_neg && !c_neg && (sum > LIM));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      mode     <= '0;
      work     <= '0;
      idx      <= '0;
      cnt      <= '0;
      ones     <= '0;
      o_result <= '0;
      o_error  <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            mode <= i_mode;
            if (arg_err) begin
              state    <= DONE;
              o_result <= '0;
              o_error  <= 1'b1;
              o_done   <= 1'b1;
            end else begin
              state  <= BUSY;
              work   <= i_arg_A;
              idx    <= i_arg_B[IDXW-1:0];
              cnt    <= i_arg_C[IDXW-1:0];
              ones   <= '0;
              o_busy <= 1'b1;
            end
          end
        end
        BUSY: begin
          work <= work_nx;
          ones <= ones_nx;
          cnt  <= cnt - IDXW'(1);
          if (cnt == IDXW'(1)) begin
            // Last bit: publish the result that includes this clock's update.
            state    <= DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_error  <= 1'b0;
            o_result <= (mode == 2'b11) ? {{(BITS-IDXW){1'b0}}, ones_nx} : work_nx;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ustawienie_pola.sv
// Directed bench for ustawienie_pola (BITS=32): vector table plus handshake and reset sequences.
module tb_ustawienie_pola;
  localparam int BITS = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_start;
  logic [1:0]      i_mode;
  logic [BITS-1:0] i_arg_A, i_arg_B, i_arg_C;
  logic [BITS-1:0] o_result;
  logic            o_error, o_busy, o_done;

  int n_cmp  = 0;
  int n_fail = 0;

  ustawienie_pola #(.BITS(BITS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_arg_A(i_arg_A), .i_arg_B(i_arg_B), .i_arg_C(i_arg_C),
    .o_result(o_result), .o_error(o_error), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a, b, c;
    logic [31:0] res;
    logic        err;
    int          busy_n;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int waits, nbusy;
    bit got;
    @(negedge i_clk);
    i_mode = v.mode; i_arg_A = v.a; i_arg_B = v.b; i_arg_C = v.c; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_mode = 2'($urandom); i_arg_A = $urandom; i_arg_B = $urandom; i_arg_C = $urandom;
    waits = 0; nbusy = 0; got = 0;
    while (!got && waits < 200) begin
      @(negedge i_clk);
      if (o_done) got = 1;
      else begin
        if (o_busy) nbusy++;
        waits++;
      end
    end
    check($sformatf("v%0d done_seen", n), 32'(got), 32'd1);
    check($sformatf("v%0d latency", n), 32'(waits), 32'(v.busy_n));
    check($sformatf("v%0d busy_periods", n), 32'(nbusy), 32'(v.busy_n));
    check($sformatf("v%0d busy_at_done", n), 32'(o_busy), 32'd0);
    check($sformatf("v%0d result", n), o_result, v.res);
    check($sformatf("v%0d error", n), 32'(o_error), 32'(v.err));
    @(negedge i_clk);
    check($sformatf("v%0d done_pulse", n), 32'(o_done), 32'd0);
    check($sformatf("v%0d result_hold", n), o_result, v.res);
  endtask

  initial begin
    int dones;
    bit seen;
    vecs[0]  = '{2'b00, 32'h0000_0000, 32'd4,  32'd8,  32'h0000_0FF0, 1'b0, 8};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'd28, 32'd4,  32'h0FFF_FFFF, 1'b0, 4};
    vecs[2]  = '{2'b10, 32'hAAAA_AAAA, 32'd0,  32'd32, 32'h5555_5555, 1'b0, 32};
    vecs[3]  = '{2'b11, 32'hF0F0_F0F0, 32'd0,  32'd16, 32'd8,         1'b0, 16};
    vecs[4]  = '{2'b11, 32'hF0F0_F0F0, 32'd4,  32'd4,  32'd4,         1'b0, 4};
    vecs[5]  = '{2'b10, 32'h1234_5678, 32'd8,  32'd8,  32'h1234_A978, 1'b0, 8};
    vecs[6]  = '{2'b11, 32'h8000_0000, 32'd31, 32'd1,  32'd1,         1'b0, 1};
    vecs[7]  = '{2'b00, 32'h1234_5678, 32'd32, 32'd1,  32'd0,         1'b1, 0};
    vecs[8]  = '{2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 32'd1, 32'd0,   1'b1, 0};
    vecs[9]  = '{2'b01, 32'h1234_5678, 32'h8000_0000, 32'd1, 32'd0,   1'b1, 0};
    vecs[10] = '{2'b10, 32'h1234_5678, 32'd0,  32'd0,  32'd0,         1'b1, 0};
    vecs[11] = '{2'b11, 32'h1234_5678, 32'd0,  32'h8000_0000, 32'd0,  1'b1, 0};
    vecs[12] = '{2'b00, 32'h1234_5678, 32'd30, 32'd4,  32'd0,         1'b1, 0};
    vecs[13] = '{2'b00, 32'h1234_5678, 32'd1,  32'hFFFF_FFFF, 32'd0,  1'b1, 0};
    vecs[14] = '{2'b00, 32'h1234_5678, 32'd0,  32'd33, 32'd0,         1'b1, 0};
    vecs[15] = '{2'b01, 32'hFFFF_FFFF, 32'd0,  32'd1,  32'hFFFF_FFFE, 1'b0, 1};

    i_rst_n = 1'b0; i_start = 1'b0; i_mode = '0;
    i_arg_A = '0; i_arg_B = '0; i_arg_C = '0;
    repeat (3) @(negedge i_clk);
    check("rst result", o_result, 32'd0);
    check("rst error", 32'(o_error), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Held start: exactly one request runs, inputs changed under it are ignored.
    @(negedge i_clk);
    i_mode = 2'b00; i_arg_A = '0; i_arg_B = 32'd0; i_arg_C = 32'd8; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_mode = 2'b11; i_arg_A = 32'hFFFF_FFFF; i_arg_B = 32'd0; i_arg_C = 32'd3;
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      check($sformatf("hs busy%0d", k), 32'(o_busy), 32'd1);
      if (o_done) dones++;
    end
    @(negedge i_clk);
    if (o_done) dones++;
    check("hs result", o_result, 32'h0000_00FF);
    check("hs busy_at_done", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    if (o_done) dones++;
    check("hs done_count", 32'(dones), 32'd1);
    check("hs idle_busy", 32'(o_busy), 32'd0);
    check("hs idle_hold", o_result, 32'h0000_00FF);
    @(negedge i_clk);
    check("hs second_accept", 32'(o_busy), 32'd1);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("hs second_busy", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    check("hs second_done", 32'(o_done), 32'd1);
    check("hs second_result", o_result, 32'd3);

    // Reset during the 3rd BUSY period of a C=10 request.
    @(negedge i_clk);
    i_mode = 2'b00; i_arg_A = '0; i_arg_B = 32'd0; i_arg_C = 32'd10; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rb busy_before", 32'(o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("rb result", o_result, 32'd0);
    check("rb busy", 32'(o_busy), 32'd0);
    check("rb done", 32'(o_done), 32'd0);
    check("rb error", 32'(o_error), 32'd0);
    seen = 0;
    repeat (2) @(negedge i_clk) if (o_done) seen = 1;
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk) if (o_done || o_busy) seen = 1;
    check("rb no_done", 32'(seen), 32'd0);
    run_vec('{2'b00, 32'h0, 32'd0, 32'd1, 32'h0000_0001, 1'b0, 1}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
